instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the R-type field decoder (R_Instr).
- Owns the PC and issues word reads to instruction memory.
- Delivers each fetched 32-bit instr_word, with its PC, to decode over a valid/ready handshake.
- Supports branch/jump redirect; discards any stale in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  XLEN  fetch address (word aligned).
- imem_rsp_valid  in  1  read data valid. Arrives 1 or more cycles after the request is accepted.
- imem_rdata  in  XLEN  fetched instruction.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode consumes the instruction this cycle.
- id_instr  out  XLEN  instr_word to the decoder.
- id_pc  out  XLEN  PC of id_instr.
- redirect_valid  in  1  control-flow redirect (1-cycle pulse or held).
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored (forced to 0).

Behaviour:
- Reset (async, active-high): state=REQ, pc=RESET_PC, imem_req_valid=0 while rst is high, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, drop=0. imem_req_valid rises the first cycle after rst deasserts.
- At most one request is outstanding. A single-entry output register doubles as the hold buffer.
- States:
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_valid && imem_req_ready -> WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid:
    - if drop=1: discard the response, clear drop -> REQ.
    - otherwise: load id_instr=imem_rdata, id_pc=pc, id_valid=1, pc=pc+4 -> HOLD.
  - HOLD: id_valid=1; outputs are stable while id_ready=0. On id_ready, id_valid drops next cycle -> REQ.
- Latency: with a zero-wait memory (ready=1, rsp one cycle after accept), instructions are delivered every 3 cycles. No throughput optimisation is required.
- Redirect has priority over every other event in the same cycle:
  - pc <= {redirect_pc[31:2],2'b00}; id_valid <= 0. A held instruction is flushed even if id_ready=1 in the same cycle.
  - in WAIT without a same-cycle rsp: set drop=1 and stay in WAIT.
  - in WAIT with a same-cycle rsp: discard the response -> REQ.
  - in REQ with the request accepted the same cycle: the request goes out with the old pc, drop=1 -> WAIT.
  - in REQ without acceptance: imem_addr switches to the new pc next cycle.
  - in HOLD: -> REQ.
- The request handshake holds imem_addr stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000 (modulo 2^32, no flag).
- imem_rsp_valid in REQ or HOLD is a protocol violation: ignore it. An assertion fires under simulation.
- Reset mid-operation clears drop; a late response after reset is ignored because the state is REQ.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined:
  - adds output port fetch_count (32 bits), reset to 0, incremented on each id_valid && id_ready handshake; wraps at 2^32.
  - adds output port flush_count (32 bits), incremented on each redirect that discards a held or in-flight instruction.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Shared package rv_pkg:
  - XLEN
  - NOP_INSTR (32'h0000_0013)
  - RESET_PC default
  - fetch state enum (IFU_REQ, IFU_WAIT, IFU_HOLD)
- One natural sub-module, ifu_pc_reg: holds the PC register with increment/redirect selection and alignment masking. The FSM and output register stay in instr_fetch_unit.

Test Plan:
- Reset: RESET_PC=32'h100; hold rst 3 cycles, release.
  -> imem_req_valid=1 with imem_addr=32'h100 one cycle after release; id_valid=0, id_instr=32'h13.
- Basic fetch: memory returns 32'h0234AB60 at 0x100 and 32'h405A8333 at 0x104; id_ready=1.
  -> id_instr sequence 32'h0234AB60 (id_pc 0x100), then 32'h405A8333 (id_pc 0x104); the downstream R_Instr shows rs2=5, rs1=21, rd=6 for the second word.
- Backpressure: id_ready=0 for 5 cycles after id_valid.
  -> id_instr/id_pc stable, no new imem request; one request at 0x108 after id_ready=1.
- Redirect in WAIT: redirect_valid pulse with redirect_pc=32'h200 while the 0x108 request is outstanding.
  -> that response is discarded (never on id_instr); next request addr=32'h200; id_pc=32'h200 on the next delivered instruction.
- Redirect and id_ready in the same HOLD cycle; redirect_pc=32'h303.
  -> no handshake counted, id_valid=0 next cycle, imem_addr=32'h300.
- Wrap: redirect to 32'hFFFF_FFFC, complete one fetch -> next imem_addr=32'h0. With IFU_PERF_CNT_EN: fetch_count and flush_count match the expected totals at the end.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: widths, NOP encoding, reset PC and FSM state type.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

  // Payload handed to decode
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifu_fetch_t;

  // Force an address onto a word boundary
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handoff and redirect.
interface instr_fetch_unit_if;
  import rv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rdata;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, id_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rdata, id_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifu_pc_reg.sv
// Program counter: redirect (word-aligned) takes priority over sequential increment.
module ifu_pc_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  // PC update; increment wraps modulo 2^XLEN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= align_word(i_redirect_pc);
    end else if (i_inc) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read, single-entry output/hold register,
// redirect with stale-response discard.
// Optional macro IFU_PERF_CNT_EN adds fetch_count/flush_count ports.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
  parameter int unsigned XLEN     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_unit_if.master        bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]               fetch_count,
  output logic [31:0]               flush_count
`endif
);
  import rv_pkg::*;

  ifu_state_e  r_state;
  logic        r_drop;
  logic        r_req_valid;
  logic        r_id_valid;
  ifu_fetch_t  r_out;

  logic [XLEN-1:0] w_pc;
  logic            w_accept;
  logic            w_redirect;
  logic            w_rsp;
  logic            w_load;

  // Event decode; a response only counts while waiting for one
  assign w_accept   = r_req_valid && bus.imem_req_ready;
  assign w_redirect = bus.redirect_valid;
  assign w_rsp      = bus.imem_rsp_valid && (r_state == IFU_WAIT);
  assign w_load     = w_rsp && !r_drop && !w_redirect;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .i_inc         (w_load),
    .i_redirect    (w_redirect),
    .i_redirect_pc (bus.redirect_pc),
    .o_pc          (w_pc)
  );

  // Fetch FSM with registered request and decode outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IFU_REQ;
      r_drop      <= 1'b0;
      r_req_valid <= 1'b0;
      r_id_valid  <= 1'b0;
      r_out       <= '{instr: NOP_INSTR, pc: '0};
    end else begin
      case (r_state)
        IFU_REQ: begin
          r_req_valid <= 1'b1;
          if (w_accept) begin
            // A redirect here lets the old-pc request go out but marks it stale
            r_state     <= IFU_WAIT;
            r_req_valid <= 1'b0;
            r_drop      <= w_redirect;
          end
        end
        IFU_WAIT: begin
          if (w_rsp) begin
            r_drop      <= 1'b0;
            r_state     <= IFU_REQ;
            r_req_valid <= 1'b1;
            if (w_load) begin
              r_out       <= '{instr: bus.imem_rdata, pc: w_pc};
              r_id_valid  <= 1'b1;
              r_state     <= IFU_HOLD;
              r_req_valid <= 1'b0;
            end
          end else if (w_redirect) begin
            r_drop <= 1'b1;
          end
        end
        IFU_HOLD: begin
          // Redirect flushes the held word even if decode takes it this cycle
          if (w_redirect || bus.id_ready) begin
            r_id_valid  <= 1'b0;
            r_state     <= IFU_REQ;
            r_req_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IFU_REQ;
          r_req_valid <= 1'b0;
          r_id_valid  <= 1'b0;
          r_drop      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_addr      = w_pc;
  assign bus.id_valid       = r_id_valid;
  assign bus.id_instr       = r_out.instr;
  assign bus.id_pc          = r_out.pc;

`ifdef IFU_PERF_CNT_EN
  logic w_fetch_hs;
  logic w_flush;
  logic [31:0] r_fetch_count;
  logic [31:0] r_flush_count;

  assign w_fetch_hs = r_id_valid && bus.id_ready && !w_redirect;
  assign w_flush    = w_redirect &&
                      ((r_state == IFU_HOLD) ||
                       ((r_state == IFU_WAIT) && !r_drop) ||
                       ((r_state == IFU_REQ) && w_accept));

  // Handshake and flush counters, free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_fetch_hs) r_fetch_count <= r_fetch_count + 32'(1);
      if (w_flush)    r_flush_count <= r_flush_count + 32'(1);
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

  // Responses are only legal while a request is outstanding
  a_rsp_only_in_wait: assert property (
    @(posedge clk) disable iff (rst) bus.imem_rsp_valid |-> (r_state == IFU_WAIT)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small instruction-memory responder.
module tb_instr_fetch_unit;
  import rv_pkg::*;

  logic clk;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   mem_lat = 1;

  instr_fetch_unit_if bus();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .XLEN     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: return 32'h0234_AB60;
      32'h0000_0104: return 32'h405A_8333;
      32'h0000_0108: return 32'hDEAD_0108;
      default:       return addr ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory: returns data mem_lat cycles after each accepted request
  initial begin
    bit          acc;
    logic [31:0] a;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = '0;
    forever begin
      @(posedge clk);
      acc = bus.imem_req_valid && bus.imem_req_ready && !rst;
      a   = bus.imem_addr;
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (acc) begin
        repeat (mem_lat - 1) begin
          @(posedge clk);
          #1;
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata     = mem_word(a);
      end
    end
  end

  task automatic wait_id(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.id_valid && cyc < 20);
    chk({tag, "_id_valid"}, 32'(bus.id_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int cyc  = 0;
    int seen = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.id_valid) seen++;
    end while (!bus.imem_req_valid && cyc < 20);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd1);
    chk({tag, "_stale_seen"}, 32'(seen), 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, exp_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_id_valid",  32'(bus.id_valid),       32'd0);
    chk("rst_id_instr",  bus.id_instr,            32'h0000_0013);
    chk("rst_id_pc",     bus.id_pc,               32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rel_addr",      bus.imem_addr,           32'h0000_0100);
    chk("rel_id_valid",  32'(bus.id_valid),       32'd0);
    chk("rel_id_instr",  bus.id_instr,            32'h0000_0013);

    // Basic fetch
    bus.id_ready = 1'b1;
    wait_id("w100", cyc);
    chk("w100_instr", bus.id_instr, 32'h0234_AB60);
    chk("w100_pc",    bus.id_pc,    32'h0000_0100);
    wait_id("w104", cyc);
    chk("cadence",    32'(cyc),     32'd3);
    chk("w104_instr", bus.id_instr, 32'h405A_8333);
    chk("w104_pc",    bus.id_pc,    32'h0000_0104);
    chk("w104_rs2",   32'(bus.id_instr[24:20]), 32'd5);
    chk("w104_rs1",   32'(bus.id_instr[19:15]), 32'd21);
    chk("w104_rd",    32'(bus.id_instr[11:7]),  32'd6);

    // Backpressure on the held word
    bus.id_ready = 1'b0;
    mem_lat      = 3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_id_valid",  32'(bus.id_valid),       32'd1);
      chk("bp_instr",     bus.id_instr,            32'h405A_8333);
      chk("bp_pc",        bus.id_pc,               32'h0000_0104);
      chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
    end
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_id_valid",  32'(bus.id_valid),       32'd0);
    chk("bp_rel_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("bp_rel_addr",      bus.imem_addr,           32'h0000_0108);

    // Redirect while the 0x108 read is outstanding
    @(negedge clk);
    chk("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    mem_lat            = 1;
    wait_req("rdw", 32'h0000_0200);
    wait_id("w200", cyc);
    chk("w200_pc",    bus.id_pc,    32'h0000_0200);
    chk("w200_instr", bus.id_instr, 32'h5A5A_0200);

    // Redirect and id_ready together in HOLD
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0303;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("rdh_id_valid",  32'(bus.id_valid),       32'd0);
    chk("rdh_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rdh_addr",      bus.imem_addr,           32'h0000_0300);
    wait_id("w300", cyc);
    chk("w300_pc",    bus.id_pc,    32'h0000_0300);
    chk("w300_instr", bus.id_instr, 32'h5A5A_0300);

    // Address held while memory stalls, then redirect without acceptance
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("stall_addr",      bus.imem_addr,           32'h0000_0304);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("rdq_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rdq_addr",      bus.imem_addr,           32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    wait_id("wtop", cyc);
    chk("wtop_pc",    bus.id_pc,    32'hFFFF_FFFC);
    chk("wtop_instr", bus.id_instr, 32'hA5A5_FFFC);
    @(negedge clk);
    chk("wrap_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("wrap_addr",      bus.imem_addr,           32'h0000_0000);

    // Redirect in the same cycle the request is accepted
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0400;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("rda_req_valid", 32'(bus.imem_req_valid), 32'd0);
    wait_req("rda", 32'h0000_0400);
    wait_id("w400", cyc);
    chk("w400_pc",    bus.id_pc,    32'h0000_0400);
    chk("w400_instr", bus.id_instr, 32'h5A5A_0400);

    // Redirect in WAIT with the response arriving the same cycle
    @(negedge clk);
    chk("w404_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("w404_addr",      bus.imem_addr,           32'h0000_0404);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0500;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("rds_id_valid",  32'(bus.id_valid),       32'd0);
    chk("rds_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rds_addr",      bus.imem_addr,           32'h0000_0500);
    wait_id("w500", cyc);
    chk("w500_pc",    bus.id_pc,    32'h0000_0500);
    chk("w500_instr", bus.id_instr, 32'h5A5A_0500);
    @(negedge clk);

`ifdef IFU_PERF_CNT_EN
    chk("fetch_count", fetch_count, 32'd6);
    chk("flush_count", flush_count, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
